// File: rtl/dst_axis_framer.sv
// Output-stream framer: 2-entry skid buffer toward M_AXIS with per-frame TLAST generation.
// Optional statistics counters (fr_cnt, st_cnt) are enabled by defining DST_AXIS_FRAMER_STAT_EN.
module dst_axis_framer #(
    parameter int unsigned DW = 32,
    parameter int unsigned LW = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [LW-1:0]   ds,
    input  logic            s_valid,
    input  logic [DW-1:0]   s_data,
    output logic            s_ready,
    output logic            m_valid,
    output logic [DW-1:0]   m_data,
    output logic [DW/8-1:0] m_strb,
    output logic            m_last,
    input  logic            m_ready,
    output logic            busy,
    output logic            done
`ifdef DST_AXIS_FRAMER_STAT_EN
    ,
    output logic [15:0]     fr_cnt,
    output logic [15:0]     st_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e          state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic            s_ready_q, s_ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Output register
    logic            mv_q, mv_d;
    logic [DW-1:0]   md_q, md_d;
    logic            ml_q, ml_d;

    // Skid register
    logic            sv_q, sv_d;
    logic [DW-1:0]   sd_q, sd_d;
    logic            sl_q, sl_d;

    logic            acc;
    logic            acc_last;
    logic            out_fire;
    logic            last_hs;

    always_comb begin
        acc      = s_valid & s_ready_q;
        // Last tag is captured with the word so output stalls cannot shift it.
        acc_last = (cnt_q == (len_q - 1'b1));
        out_fire = mv_q & m_ready;
        last_hs  = out_fire & ml_q;
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start && (ds != '0)) begin
                    state_d = StRun;
                    len_d   = ds;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                if (acc) begin
                    cnt_d = cnt_q + 1'b1;
                    if (acc_last) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (last_hs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mv_d = mv_q;
        md_d = md_q;
        ml_d = ml_q;
        sv_d = sv_q;
        sd_d = sd_q;
        sl_d = sl_q;
        if (!mv_q || m_ready) begin
            if (sv_q) begin
                mv_d = 1'b1;
                md_d = sd_q;
                ml_d = sl_q;
                sv_d = acc;
                if (acc) begin
                    sd_d = s_data;
                    sl_d = acc_last;
                end
            end else begin
                mv_d = acc;
                if (acc) begin
                    md_d = s_data;
                    ml_d = acc_last;
                end
            end
        end else if (acc) begin
            // Output stalled: park the in-flight word in the skid entry.
            sv_d = 1'b1;
            sd_d = s_data;
            sl_d = acc_last;
        end
    end

    always_comb begin
        s_ready_d = (state_d == StRun) && !sv_d;
        busy_d    = (state_d != StIdle) || mv_d;
        done_d    = last_hs && (state_q == StDrain);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            len_q     <= '0;
            cnt_q     <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mv_q      <= 1'b0;
            md_q      <= '0;
            ml_q      <= 1'b0;
            sv_q      <= 1'b0;
            sd_q      <= '0;
            sl_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            s_ready_q <= s_ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            mv_q      <= mv_d;
            md_q      <= md_d;
            ml_q      <= ml_d;
            sv_q      <= sv_d;
            sd_q      <= sd_d;
            sl_q      <= sl_d;
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = mv_q;
    assign m_data  = md_q;
    assign m_last  = ml_q;
    assign m_strb  = {(DW/8){mv_q}};
    assign busy    = busy_q;
    assign done    = done_q;

`ifdef DST_AXIS_FRAMER_STAT_EN
    logic [15:0] fr_cnt_q, fr_cnt_d;
    logic [15:0] st_cnt_q, st_cnt_d;

    always_comb begin
        fr_cnt_d = fr_cnt_q;
        st_cnt_d = st_cnt_q;
        if (done_d) begin
            fr_cnt_d = fr_cnt_q + 16'd1;
        end
        if (mv_q && !m_ready && (st_cnt_q != 16'hFFFF)) begin
            st_cnt_d = st_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fr_cnt_q <= '0;
            st_cnt_q <= '0;
        end else begin
            fr_cnt_q <= fr_cnt_d;
            st_cnt_q <= st_cnt_d;
        end
    end

    assign fr_cnt = fr_cnt_q;
    assign st_cnt = st_cnt_q;
`endif

endmodule

// File: tb/tb_dst_axis_framer.sv
// Directed bench for dst_axis_framer: framing, TLAST placement, stalls, reset and start filtering.
module tb_dst_axis_framer;

    localparam int unsigned DW = 32;
    localparam int unsigned LW = 12;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [LW-1:0]   ds;
    logic            s_valid;
    logic [DW-1:0]   s_data;
    logic            s_ready;
    logic            m_valid;
    logic [DW-1:0]   m_data;
    logic [DW/8-1:0] m_strb;
    logic            m_last;
    logic            m_ready;
    logic            busy;
    logic            done;
`ifdef DST_AXIS_FRAMER_STAT_EN
    logic [15:0]     fr_cnt;
    logic [15:0]     st_cnt;
`endif

    int vecs = 0;
    int errs = 0;

    dst_axis_framer #(.DW(DW), .LW(LW)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .ds      (ds),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_strb  (m_strb),
        .m_last  (m_last),
        .m_ready (m_ready),
        .busy    (busy),
        .done    (done)
`ifdef DST_AXIS_FRAMER_STAT_EN
        ,
        .fr_cnt  (fr_cnt),
        .st_cnt  (st_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; ds = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        step(); step();
        vecs++; if (s_ready !== 1'b0) begin errs++; $display("FAIL reset.s_ready got %b want 0", s_ready); end
        vecs++; if (m_valid !== 1'b0) begin errs++; $display("FAIL reset.m_valid got %b want 0", m_valid); end
        vecs++; if (m_last !== 1'b0) begin errs++; $display("FAIL reset.m_last got %b want 0", m_last); end
        vecs++; if (m_data !== 32'h0) begin errs++; $display("FAIL reset.m_data got %h want 0", m_data); end
        vecs++; if (m_strb !== 4'h0) begin errs++; $display("FAIL reset.m_strb got %h want 0", m_strb); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset.busy got %b want 0", busy); end
        vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset.done got %b want 0", done); end
        reset = 1'b0;
        step();
        vecs++; if (s_ready !== 1'b0) begin errs++; $display("FAIL idle.s_ready got %b want 0", s_ready); end
    endtask

    task automatic test_basic();
        ds = 12'd4; start = 1'b1; s_valid = 1'b1; s_data = 32'd1; m_ready = 1'b1;
        step();
        start = 1'b0;
        vecs++; if (s_ready !== 1'b1) begin errs++; $display("FAIL basic.s_ready_open got %b want 1", s_ready); end
        vecs++; if (m_valid !== 1'b0) begin errs++; $display("FAIL basic.latency got %b want 0", m_valid); end
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL basic.busy got %b want 1", busy); end
        step();
        for (int i = 1; i <= 4; i++) begin
            vecs++; if (m_valid !== 1'b1) begin errs++; $display("FAIL basic.m_valid[%0d] got %b want 1", i, m_valid); end
            vecs++; if (m_data !== 32'(i)) begin errs++; $display("FAIL basic.m_data[%0d] got %h want %h", i, m_data, 32'(i)); end
            vecs++; if (m_last !== (i == 4)) begin errs++; $display("FAIL basic.m_last[%0d] got %b want %b", i, m_last, (i == 4)); end
            vecs++; if (m_strb !== 4'hF) begin errs++; $display("FAIL basic.m_strb[%0d] got %h want f", i, m_strb); end
            s_data = 32'(i + 1);
            step();
        end
        vecs++; if (done !== 1'b1) begin errs++; $display("FAIL basic.done got %b want 1", done); end
        vecs++; if (m_valid !== 1'b0) begin errs++; $display("FAIL basic.no_extra got %b want 0", m_valid); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL basic.busy_end got %b want 0", busy); end
        s_valid = 1'b0;
        step();
        vecs++; if (done !== 1'b0) begin errs++; $display("FAIL basic.done_pulse got %b want 0", done); end
    endtask

    task automatic test_stall();
        logic [31:0] exp_w [3];
        int          in_idx = 0;
        int          out_idx = 0;
        int          cyc = 0;
        logic        stalled = 1'b0;
        logic [31:0] held_d = '0;
        logic        held_l = 1'b0;
        logic        fire_in;
        exp_w[0] = 32'hA; exp_w[1] = 32'hB; exp_w[2] = 32'hC;
        ds = 12'd3; start = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        step();
        start = 1'b0;
        while (out_idx < 3 && cyc < 40) begin
            m_ready = (cyc % 2 == 0);
            s_valid = (in_idx < 3);
            s_data  = (in_idx < 3) ? exp_w[in_idx] : 32'h0;
            if (stalled) begin
                vecs++; if (m_valid !== 1'b1 || m_data !== held_d || m_last !== held_l) begin
                    errs++; $display("FAIL stall.hold got v=%b d=%h l=%b want v=1 d=%h l=%b",
                                     m_valid, m_data, m_last, held_d, held_l);
                end
            end
            fire_in = s_valid && s_ready;
            if (m_valid && m_ready) begin
                vecs++; if (m_data !== exp_w[out_idx]) begin errs++; $display("FAIL stall.data[%0d] got %h want %h", out_idx, m_data, exp_w[out_idx]); end
                vecs++; if (m_last !== (out_idx == 2)) begin errs++; $display("FAIL stall.last[%0d] got %b want %b", out_idx, m_last, (out_idx == 2)); end
                out_idx++;
            end
            stalled = m_valid && !m_ready;
            held_d  = m_data;
            held_l  = m_last;
            step();
            if (fire_in) in_idx++;
            cyc++;
        end
        vecs++; if (out_idx !== 3) begin errs++; $display("FAIL stall.count got %0d want 3", out_idx); end
        vecs++; if (in_idx !== 3) begin errs++; $display("FAIL stall.accepts got %0d want 3", in_idx); end
        vecs++; if (done !== 1'b1) begin errs++; $display("FAIL stall.done got %b want 1", done); end
        vecs++; if (m_valid !== 1'b0) begin errs++; $display("FAIL stall.no_dup got %b want 0", m_valid); end
        s_valid = 1'b0; m_ready = 1'b1;
        step();
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL stall.busy_end got %b want 0", busy); end
    endtask

    task automatic test_len_edges();
        ds = 12'd1; start = 1'b1; s_valid = 1'b1; s_data = 32'h55; m_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        vecs++; if (m_valid !== 1'b1 || m_data !== 32'h55) begin errs++; $display("FAIL len1.word got v=%b d=%h want v=1 d=55", m_valid, m_data); end
        vecs++; if (m_last !== 1'b1) begin errs++; $display("FAIL len1.last got %b want 1", m_last); end
        vecs++; if (s_ready !== 1'b0) begin errs++; $display("FAIL len1.s_ready got %b want 0", s_ready); end
        step();
        vecs++; if (done !== 1'b1) begin errs++; $display("FAIL len1.done got %b want 1", done); end
        ds = 12'd0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        vecs++; if (s_ready !== 1'b0) begin errs++; $display("FAIL ds0.s_ready got %b want 0", s_ready); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL ds0.busy got %b want 0", busy); end
        vecs++; if (m_valid !== 1'b0) begin errs++; $display("FAIL ds0.m_valid got %b want 0", m_valid); end
        s_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int acc_n = 0;
        int cyc = 0;
        ds = 12'd8; start = 1'b1; s_valid = 1'b1; s_data = 32'd1; m_ready = 1'b1;
        step();
        start = 1'b0;
        while (acc_n < 5 && cyc < 20) begin
            if (s_ready) acc_n++;
            step();
            s_data = s_data + 32'd1;
            cyc++;
        end
        vecs++; if (acc_n !== 5) begin errs++; $display("FAIL rstmid.accepts got %0d want 5", acc_n); end
        reset = 1'b1;
        step();
        vecs++; if (m_valid !== 1'b0) begin errs++; $display("FAIL rstmid.m_valid got %b want 0", m_valid); end
        vecs++; if (s_ready !== 1'b0) begin errs++; $display("FAIL rstmid.s_ready got %b want 0", s_ready); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rstmid.busy got %b want 0", busy); end
        vecs++; if (m_last !== 1'b0) begin errs++; $display("FAIL rstmid.m_last got %b want 0", m_last); end
        reset = 1'b0;
        ds = 12'd2; start = 1'b1; s_data = 32'h21;
        step();
        start = 1'b0;
        step();
        vecs++; if (m_data !== 32'h21 || m_last !== 1'b0) begin errs++; $display("FAIL rstmid.w0 got d=%h l=%b want d=21 l=0", m_data, m_last); end
        s_data = 32'h22;
        step();
        vecs++; if (m_data !== 32'h22 || m_last !== 1'b1) begin errs++; $display("FAIL rstmid.w1 got d=%h l=%b want d=22 l=1", m_data, m_last); end
        s_valid = 1'b0;
        step();
        vecs++; if (done !== 1'b1) begin errs++; $display("FAIL rstmid.done got %b want 1", done); end
    endtask

    task automatic test_start_ignore();
        ds = 12'd5; start = 1'b1; s_valid = 1'b1; s_data = 32'h51; m_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            vecs++; if (m_valid !== 1'b1 || m_data !== 32'(8'h51 + i)) begin
                errs++; $display("FAIL startign.data[%0d] got v=%b d=%h want v=1 d=%h", i, m_valid, m_data, 32'(8'h51 + i));
            end
            vecs++; if (m_last !== (i == 4)) begin errs++; $display("FAIL startign.last[%0d] got %b want %b", i, m_last, (i == 4)); end
            start = (i == 0) || (i == 4);
            ds = 12'd2;
            s_data = 32'(8'h52 + i);
            step();
        end
        start = 1'b0; s_valid = 1'b1;
        vecs++; if (done !== 1'b1) begin errs++; $display("FAIL startign.done got %b want 1", done); end
        vecs++; if (s_ready !== 1'b0) begin errs++; $display("FAIL startign.s_ready got %b want 0", s_ready); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL startign.busy got %b want 0", busy); end
        step();
        vecs++; if (s_ready !== 1'b0 || m_valid !== 1'b0) begin errs++; $display("FAIL startign.idle got r=%b v=%b want r=0 v=0", s_ready, m_valid); end
        s_valid = 1'b0;
    endtask

`ifdef DST_AXIS_FRAMER_STAT_EN
    task automatic test_stats();
        int cyc;
        reset = 1'b1; step(); reset = 1'b0;
        vecs++; if (fr_cnt !== 16'h0 || st_cnt !== 16'h0) begin errs++; $display("FAIL stat.reset got fr=%h st=%h want 0 0", fr_cnt, st_cnt); end
        ds = 12'd2; start = 1'b1; s_valid = 1'b1; s_data = 32'h61; m_ready = 1'b0;
        step();
        start = 1'b0;
        step();
        s_data = 32'h62;
        repeat (7) step();
        m_ready = 1'b1; s_valid = 1'b0;
        cyc = 0;
        while (!done && cyc < 10) begin step(); cyc++; end
        for (int f = 0; f < 2; f++) begin
            start = 1'b1; s_valid = 1'b1; s_data = 32'h70;
            step();
            start = 1'b0;
            cyc = 0;
            while (!done && cyc < 10) begin step(); cyc++; end
            s_valid = 1'b0;
            vecs++; if (done !== 1'b1) begin errs++; $display("FAIL stat.frame_done got %b want 1", done); end
        end
        vecs++; if (fr_cnt !== 16'd3) begin errs++; $display("FAIL stat.fr_cnt got %0d want 3", fr_cnt); end
        vecs++; if (st_cnt !== 16'd7) begin errs++; $display("FAIL stat.st_cnt got %0d want 7", st_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_len_edges();
        test_reset_mid();
        test_start_ignore();
`ifdef DST_AXIS_FRAMER_STAT_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
